hazard_ctrl_mc: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core, successor to the combinational hazard unit. It adds a parametrised register-index width, a multi-cycle multiply/divide (MDU) busy tracker, and a data-memory wait-state stall with write-back bubble insertion. It also adds a saturating stall-cycle performance counter. It sits beside the datapath and drives all forwarding mux selects and stage stall/flush enables.

---
 rtl/hazard_ctrl_mc.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the five-stage MIPS pipeline: forwarding selects,
// load/branch/jr/MDU hazard stalls, data-memory wait-state stalls with a
// write-back bubble, an MDU busy tracker and a saturating stall counter.
module hazard_ctrl_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic              jr_d,
  input  logic              mdu_start_d,
  input  logic              hilo_read_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mdu_start_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic              mem_access_m,
  input  logic              dmem_ready_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_w,
  input  logic              cnt_clr,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MDU_CW = $clog2(MDU_LAT + 1);
  localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_LAT);

  logic [MDU_CW-1:0] mduCnt;
  logic              mduActive;
  logic              lwStall;
  logic              branchStall;
  logic              jrStall;
  logic              mduStall;
  logic              memStall;
  logic              hazStall;

  // A source register hits a destination only when it is not the zero register.
  function automatic logic regHit(input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  // E-stage operand select: M result wins over W result, else register file.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (reg_write_m && regHit(src, write_reg_m))      return 2'b10;
    else if (reg_write_w && regHit(src, write_reg_w)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard detection terms, all purely combinational on current inputs.
  always_comb begin
    mduActive   = (mduCnt != '0);
    lwStall     = mem_to_reg_e &
                  (regHit(rs_d, write_reg_e) | regHit(rt_d, write_reg_e));
    branchStall = branch_d &
                  ((reg_write_e  & (regHit(rs_d, write_reg_e) | regHit(rt_d, write_reg_e))) |
                   (mem_to_reg_m & (regHit(rs_d, write_reg_m) | regHit(rt_d, write_reg_m))));
    jrStall     = jr_d &
                  ((reg_write_e  & regHit(rs_d, write_reg_e)) |
                   (mem_to_reg_m & regHit(rs_d, write_reg_m)));
    mduStall    = (mdu_start_d | hilo_read_d) & (mduActive | mdu_start_e);
    memStall    = mem_access_m & ~dmem_ready_m;
    hazStall    = lwStall | branchStall | jrStall | mduStall;
  end

  // Output decode: reset forces bubbles, memory wait freezes the whole pipe
  // and masks the front-end hazards, otherwise hazards stall F/D and bubble E.
  always_comb begin
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    mdu_busy    = 1'b0;
    if (rst) begin
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      forward_a_d = regHit(rs_d, write_reg_m) & reg_write_m & ~mem_to_reg_m;
      forward_b_d = regHit(rt_d, write_reg_m) & reg_write_m & ~mem_to_reg_m;
      forward_a_e = fwdSel(rs_e);
      forward_b_e = fwdSel(rt_e);
      mdu_busy    = mduActive;
      if (memStall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hazStall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // MDU busy countdown: an issue leaving E reloads, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mduCnt <= '0;
    end else if (mdu_start_e && !stall_e) begin
      mduCnt <= MDU_LOAD;
    end else if (mduCnt != '0) begin
      mduCnt <= mduCnt - MDU_CW'(1);
    end
  end

  // Stall-cycle performance counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_f) begin
      stall_cnt <= satInc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: two instances share stimulus, one with
// MDU_LAT=4/CNT_W=4 and one with MDU_LAT=8/CNT_W=32.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, jr_d, mdu_start_d, hilo_read_d;
  logic       reg_write_e, mem_to_reg_e, mdu_start_e;
  logic       reg_write_m, mem_to_reg_m, mem_access_m, dmem_ready_m;
  logic       reg_write_w, cnt_clr;

  logic       fad4, fbd4, sf4, sd4, se4, sm4, fe4, fw4, busy4;
  logic [1:0] fae4, fbe4;
  logic [3:0] cnt4;
  logic       fad8, fbd8, sf8, sd8, se8, sm8, fe8, fw8, busy8;
  logic [1:0] fae8, fbe8;
  logic [31:0] cnt8;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jr_d(jr_d),
    .mdu_start_d(mdu_start_d), .hilo_read_d(hilo_read_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mdu_start_e(mdu_start_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .mem_access_m(mem_access_m), .dmem_ready_m(dmem_ready_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .cnt_clr(cnt_clr),
    .forward_a_d(fad4), .forward_b_d(fbd4), .forward_a_e(fae4), .forward_b_e(fbe4),
    .stall_f(sf4), .stall_d(sd4), .stall_e(se4), .stall_m(sm4),
    .flush_e(fe4), .flush_w(fw4), .mdu_busy(busy4), .stall_cnt(cnt4));

  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(8), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jr_d(jr_d),
    .mdu_start_d(mdu_start_d), .hilo_read_d(hilo_read_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mdu_start_e(mdu_start_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .mem_access_m(mem_access_m), .dmem_ready_m(dmem_ready_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .cnt_clr(cnt_clr),
    .forward_a_d(fad8), .forward_b_d(fbd8), .forward_a_e(fae8), .forward_b_e(fbe8),
    .stall_f(sf8), .stall_d(sd8), .stall_e(se8), .stall_m(sm8),
    .flush_e(fe8), .flush_w(fw8), .mdu_busy(busy8), .stall_cnt(cnt8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    branch_d = 0; jr_d = 0; mdu_start_d = 0; hilo_read_d = 0;
    reg_write_e = 0; mem_to_reg_e = 0; mdu_start_e = 0;
    reg_write_m = 0; mem_to_reg_m = 0; mem_access_m = 0; dmem_ready_m = 0;
    reg_write_w = 0; cnt_clr = 0;
  endtask

  // Full stall/flush vector {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w}.
  function automatic logic [31:0] ctl4();
    return {26'd0, sf4, sd4, se4, sm4, fe4, fw4};
  endfunction

  initial begin
    idleInputs();
    rst = 1'b1;
    // Forwarding conditions present during reset must be suppressed.
    reg_write_m = 1; write_reg_m = 3; rs_e = 3;
    mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
    tick(); tick();
    @(negedge clk);
    chk("rst_ctl", ctl4(), 32'b000011);
    chk("rst_fwd_e", {30'd0, fae4}, 32'd0);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_cnt", {28'd0, cnt4}, 32'd0);

    tick(); rst = 1'b0; idleInputs();
    @(negedge clk);
    chk("idle_ctl", ctl4(), 32'b000000);

    // Load-use stall on rs and on rt; r0 destination never stalls.
    tick(); mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
    @(negedge clk);
    chk("lw_rs", ctl4(), 32'b110010);
    tick(); rs_d = 0; rt_d = 5;
    @(negedge clk);
    chk("lw_rt", ctl4(), 32'b110010);
    tick(); write_reg_e = 0; rt_d = 0; rs_d = 0;
    @(negedge clk);
    chk("lw_r0", ctl4(), 32'b000000);

    // E-stage forwarding priority.
    tick(); idleInputs();
    reg_write_m = 1; reg_write_w = 1; write_reg_m = 3; write_reg_w = 3; rs_e = 3; rt_e = 3;
    @(negedge clk);
    chk("fwd_a_e_m", {30'd0, fae4}, 32'd2);
    chk("fwd_b_e_m", {30'd0, fbe4}, 32'd2);
    tick(); reg_write_m = 0;
    @(negedge clk);
    chk("fwd_a_e_w", {30'd0, fae4}, 32'd1);
    tick(); rs_e = 0;
    @(negedge clk);
    chk("fwd_a_e_r0", {30'd0, fae4}, 32'd0);
    chk("fwd_b_e_w", {30'd0, fbe4}, 32'd1);

    // jr against a load in M, then branch with forwardable ALU result.
    tick(); idleInputs();
    jr_d = 1; rs_d = 7; mem_to_reg_m = 1; write_reg_m = 7; write_reg_e = 2;
    @(negedge clk);
    chk("jr_stall", ctl4(), 32'b110010);
    tick(); jr_d = 0; branch_d = 1; reg_write_m = 1; mem_to_reg_m = 0;
    @(negedge clk);
    chk("br_fwd_a_d", {31'd0, fad4}, 32'd1);
    chk("br_nostall", ctl4(), 32'b000000);
    tick(); rs_d = 0; rt_d = 7; reg_write_e = 1; write_reg_e = 7; reg_write_m = 0;
    @(negedge clk);
    chk("br_e_stall", ctl4(), 32'b110010);
    tick(); reg_write_e = 0; reg_write_m = 1; write_reg_m = 0; rt_d = 0;
    @(negedge clk);
    chk("fwd_b_d_r0", {31'd0, fbd4}, 32'd0);

    // MDU issue at T with dependent mfhi held in D.
    tick(); idleInputs(); mdu_start_e = 1; hilo_read_d = 1;
    @(negedge clk);
    chk("mdu_T_stall", {31'd0, sf4}, 32'd1);
    chk("mdu_T_busy", {31'd0, busy4}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(); mdu_start_e = 0;
      @(negedge clk);
      chk($sformatf("mdu_T%0d_stall", i), {31'd0, sf4}, 32'd1);
      chk($sformatf("mdu_T%0d_busy", i), {31'd0, busy4}, 32'd1);
    end
    tick();
    @(negedge clk);
    chk("mdu_T5_stall", {31'd0, sf4}, 32'd0);
    chk("mdu_T5_busy", {31'd0, busy4}, 32'd0);

    // MDU issue held under memstall is accepted once, when memory completes.
    tick(); idleInputs(); mdu_start_e = 1; mem_access_m = 1; dmem_ready_m = 0;
    tick();
    @(negedge clk);
    chk("mdu_held_busy", {31'd0, busy4}, 32'd0);
    tick(); dmem_ready_m = 1;
    @(negedge clk);
    chk("mdu_accept_busy", {31'd0, busy4}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(); mdu_start_e = 0;
      @(negedge clk);
      chk($sformatf("mdu_held_U%0d", i), {31'd0, busy4}, 32'd1);
    end
    tick();
    @(negedge clk);
    chk("mdu_held_U5", {31'd0, busy4}, 32'd0);

    // Memstall masks a simultaneous load-use stall for three cycles.
    tick(); idleInputs();
    mem_access_m = 1; dmem_ready_m = 0; mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("memstall_%0d", i), ctl4(), 32'b111101);
      tick();
    end
    dmem_ready_m = 1;
    @(negedge clk);
    chk("mem_done_lw", ctl4(), 32'b110010);

    // Saturating stall counter.
    tick(); idleInputs(); cnt_clr = 1;
    tick(); cnt_clr = 0; mem_to_reg_e = 1; write_reg_e = 5; rs_d = 5;
    @(negedge clk);
    chk("cnt_cleared", {28'd0, cnt4}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin
        @(negedge clk);
        chk("cnt_10", {28'd0, cnt4}, 32'd10);
      end
    end
    mem_to_reg_e = 0;
    @(negedge clk);
    chk("cnt_sat", {28'd0, cnt4}, 32'd15);
    chk("cnt8_20", cnt8, 32'd20);
    tick(); mem_to_reg_e = 1; cnt_clr = 1;
    tick(); cnt_clr = 0; mem_to_reg_e = 0;
    @(negedge clk);
    chk("cnt_clr_prio", {28'd0, cnt4}, 32'd0);

    // Reset in the middle of an 8-cycle MDU busy period.
    tick(); idleInputs(); mdu_start_e = 1;
    tick(); mdu_start_e = 0;
    @(negedge clk);
    chk("mdu8_T1_busy", {31'd0, busy8}, 32'd1);
    tick(); rst = 1;
    @(negedge clk);
    chk("mdu8_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mdu8_rst_fe", {31'd0, fe8}, 32'd1);
    tick(); rst = 0;
    @(negedge clk);
    chk("mdu8_after_rst", {31'd0, busy8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
